// File: rtl/viterbi_pkg.sv
// Purpose : shared types and constants for the Viterbi channel model.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package viterbi_pkg;

    // Error-injection modes selectable through cfg_mode.
    typedef enum logic [1:0] {
        CH_CLEAN    = 2'd0,
        CH_PERIODIC = 2'd1,
        CH_RANDOM   = 2'd2,
        CH_RBURST   = 2'd3
    } ch_mode_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] CH_LFSR_TAPS = 16'hB400;

    // Shadowed configuration fields of fixed width. thresh/window follow the
    // module parameters and are shadowed separately in the top.
    typedef struct packed {
        ch_mode_t    mode;
        logic [15:0] period;
        logic [7:0]  burst;
    } ch_cfg_t;

endpackage

// File: rtl/chan_lfsr.sv
// Purpose : Galois LFSR random source with a load and a step enable.
// Latency : value is combinational; a load is visible in the same cycle.
// Backpressure: none; the state only moves when step or load is asserted.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset (state <= SEED)
//   load      use load_val (0 replaced by 1) as the current value
//   load_val  reseed value
//   step      advance once from the current value
//   value     current LFSR value used for this cycle's decision
module chan_lfsr #(
    parameter int            W    = 16,
    parameter logic [W-1:0]  TAPS = 16'hB400,
    parameter logic [W-1:0]  SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] value
);

    logic [W-1:0] state_q;
    logic [W-1:0] seed_nz;
    logic [W-1:0] nxt;

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign seed_nz = (load_val == '0) ? {{(W-1){1'b0}}, 1'b1} : load_val;

    // A reseed applies to a symbol arriving in the same cycle.
    assign value = load ? seed_nz : state_q;
    assign nxt   = value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else if (step) begin
            state_q <= nxt;
        end else if (load) begin
            state_q <= seed_nz;
        end
    end

endmodule

// File: rtl/viterbi_channel_model.sv
// Purpose : noisy channel between encoder and Viterbi decoder; XORs an error mask onto each symbol.
// Latency : 1 cycle from valid_i/sym_i to valid_o/sym_o/err_mask_o/burst_o.
// Backpressure: none; accepts a symbol every cycle, idle cycles hold outputs and state.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cfg_load              pulse: latch cfg_*, clear counters, reseed LFSR, phase/FSM to 0
//   cfg_mode/period/burst/thresh/seed/window  configuration (used only via shadows)
//   valid_i, sym_i        clean coded symbol in
//   valid_o, sym_o        corrupted symbol out
//   err_mask_o            mask applied to sym_o
//   sym_ct_o, err_ct_o    saturating symbol and flipped-bit counters since load
//   burst_o               symbol on sym_o was corrupted by a periodic or random burst
module viterbi_channel_model #(
    parameter int                 SYM_W     = 2,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
    parameter int                 CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [1:0]        cfg_mode,
    input  logic [15:0]       cfg_period,
    input  logic [7:0]        cfg_burst,
    input  logic [LFSR_W-1:0] cfg_thresh,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [CNT_W-1:0]  cfg_window,
    input  logic              valid_i,
    input  logic [SYM_W-1:0]  sym_i,
    output logic              valid_o,
    output logic [SYM_W-1:0]  sym_o,
    output logic [SYM_W-1:0]  err_mask_o,
    output logic [CNT_W-1:0]  sym_ct_o,
    output logic [CNT_W-1:0]  err_ct_o,
    output logic              burst_o
);
    import viterbi_pkg::*;

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_BURST = 1'b1;
    localparam logic [SYM_W-1:0] ONES     = '1;

    ch_cfg_t           cfg_q, cfg_eff;
    logic [LFSR_W-1:0] thresh_q, thresh_eff;
    logic [CNT_W-1:0]  window_q, window_eff;

    logic [15:0]       phase_q, phase_eff, phase_nxt;
    logic [0:0]        st_q, st_eff, st_nxt;
    logic [7:0]        left_q, left_eff, left_nxt;

    logic [CNT_W-1:0]  sym_ct_eff, err_ct_eff, sym_ct_nxt, err_ct_nxt, pop;
    logic [CNT_W:0]    sym_sum, err_sum;

    logic [LFSR_W-1:0] lfsr_val;
    logic              inj_en, rnd_hit, burst_hit;
    logic [SYM_W-1:0]  mask;

    chan_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_W'(CH_LFSR_TAPS)),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (cfg_load),
        .load_val (cfg_seed),
        .step     (valid_i),
        .value    (lfsr_val)
    );

    // A load takes effect for a symbol arriving in the same cycle, so every
    // piece of state is viewed through its "effective" value first.
    always_comb begin
        cfg_eff        = cfg_q;
        thresh_eff     = thresh_q;
        window_eff     = window_q;
        phase_eff      = phase_q;
        st_eff         = st_q;
        left_eff       = left_q;
        sym_ct_eff     = sym_ct_o;
        err_ct_eff     = err_ct_o;
        if (cfg_load) begin
            cfg_eff.mode   = ch_mode_t'(cfg_mode);
            cfg_eff.period = cfg_period;
            cfg_eff.burst  = cfg_burst;
            thresh_eff     = cfg_thresh;
            window_eff     = cfg_window;
            phase_eff      = '0;
            st_eff         = ST_IDLE;
            left_eff       = '0;
            sym_ct_eff     = '0;
            err_ct_eff     = '0;
        end
    end

    assign inj_en  = (cfg_eff.mode != CH_CLEAN) &&
                     ((window_eff == '0) || (sym_ct_eff < window_eff));
    assign rnd_hit = (lfsr_val < thresh_eff);

    // Mask generation plus next phase / burst FSM state for a valid symbol.
    always_comb begin
        mask      = '0;
        burst_hit = 1'b0;
        phase_nxt = phase_eff;
        st_nxt    = st_eff;
        left_nxt  = left_eff;
        case (cfg_eff.mode)
            CH_PERIODIC: begin
                if (cfg_eff.period != 16'd0) begin
                    phase_nxt = (phase_eff >= cfg_eff.period - 16'd1) ? 16'd0 : phase_eff + 16'd1;
                    if (inj_en && (phase_eff < 16'(cfg_eff.burst))) begin
                        mask      = ONES;
                        burst_hit = 1'b1;
                    end
                end
            end
            CH_RANDOM: begin
                if (inj_en && rnd_hit) begin
                    mask = (lfsr_val[SYM_W-1:0] == '0) ? ONES : lfsr_val[SYM_W-1:0];
                end
            end
            CH_RBURST: begin
                if (st_eff == ST_BURST) begin
                    // Burst length is counted in valid symbols; random hits are ignored here.
                    if (inj_en) begin
                        mask      = ONES;
                        burst_hit = 1'b1;
                    end
                    left_nxt = left_eff - 8'd1;
                    if (left_eff == 8'd1) begin
                        st_nxt = ST_IDLE;
                    end
                end else if (inj_en && rnd_hit && (cfg_eff.burst != 8'd0)) begin
                    // The trigger symbol is the first symbol of the burst.
                    mask      = ONES;
                    burst_hit = 1'b1;
                    if (cfg_eff.burst != 8'd1) begin
                        st_nxt   = ST_BURST;
                        left_nxt = cfg_eff.burst - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < SYM_W; i++) begin
            pop = pop + CNT_W'(mask[i]);
        end
    end

    // Saturating counters: an overflow carry pins the count at all ones.
    assign sym_sum    = {1'b0, sym_ct_eff} + {{CNT_W{1'b0}}, 1'b1};
    assign err_sum    = {1'b0, err_ct_eff} + {1'b0, pop};
    assign sym_ct_nxt = !valid_i ? sym_ct_eff : (sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0]);
    assign err_ct_nxt = !valid_i ? err_ct_eff : (err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q    <= '{mode: CH_CLEAN, period: 16'd0, burst: 8'd0};
            thresh_q <= '0;
            window_q <= '0;
            phase_q  <= '0;
            st_q     <= ST_IDLE;
            left_q   <= '0;
        end else begin
            cfg_q    <= cfg_eff;
            thresh_q <= thresh_eff;
            window_q <= window_eff;
            phase_q  <= valid_i ? phase_nxt : phase_eff;
            st_q     <= valid_i ? st_nxt    : st_eff;
            left_q   <= valid_i ? left_nxt  : left_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o    <= 1'b0;
            sym_o      <= '0;
            err_mask_o <= '0;
            burst_o    <= 1'b0;
            sym_ct_o   <= '0;
            err_ct_o   <= '0;
        end else begin
            valid_o  <= valid_i;
            sym_ct_o <= sym_ct_nxt;
            err_ct_o <= err_ct_nxt;
            if (valid_i) begin
                sym_o      <= sym_i ^ mask;
                err_mask_o <= mask;
                burst_o    <= burst_hit;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_channel_model.sv
// Purpose : self-checking bench for viterbi_channel_model against a behavioural channel model.
// Latency : expects outputs one cycle after each driven symbol.
// Backpressure: n/a (bench drives one symbol or idle per cycle).
module tb_viterbi_channel_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_burst;
    logic [15:0] cfg_thresh;
    logic [15:0] cfg_seed;
    logic [31:0] cfg_window;
    logic        valid_i;
    logic [1:0]  sym_i;
    logic        valid_o;
    logic [1:0]  sym_o;
    logic [1:0]  err_mask_o;
    logic [31:0] sym_ct_o;
    logic [31:0] err_ct_o;
    logic        burst_o;

    always #5 clk = ~clk;

    viterbi_channel_model dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_burst  (cfg_burst),
        .cfg_thresh (cfg_thresh),
        .cfg_seed   (cfg_seed),
        .cfg_window (cfg_window),
        .valid_i    (valid_i),
        .sym_i      (sym_i),
        .valid_o    (valid_o),
        .sym_o      (sym_o),
        .err_mask_o (err_mask_o),
        .sym_ct_o   (sym_ct_o),
        .err_ct_o   (err_ct_o),
        .burst_o    (burst_o)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural channel model: symbol index since load, plain integer state.
    int          m_mode, m_period, m_burst, m_left;
    int unsigned m_thresh, m_window, m_lfsr;
    longint      m_k, m_symct, m_errct;
    logic        e_valid, e_burst;
    logic [1:0]  e_sym, e_mask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned lfsr_step(input int unsigned x);
        return ((x >> 1) ^ (((x & 1) != 0) ? 32'hB400 : 32'h0)) & 32'hFFFF;
    endfunction

    function automatic int popc(input int x);
        int c = 0;
        for (int i = 0; i < 2; i++) c += (x >> i) & 1;
        return c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_period = 0; m_burst = 0; m_left = 0;
        m_thresh = 0; m_window = 0; m_lfsr = 32'hACE1;
        m_k = 0; m_symct = 0; m_errct = 0;
        e_valid = 0; e_burst = 0; e_sym = 0; e_mask = 0;
    endtask

    task automatic model_load();
        m_mode   = int'(cfg_mode);
        m_period = int'(cfg_period);
        m_burst  = int'(cfg_burst);
        m_thresh = cfg_thresh;
        m_window = cfg_window;
        m_lfsr   = (cfg_seed == 16'd0) ? 1 : cfg_seed;
        m_k = 0; m_left = 0; m_symct = 0; m_errct = 0;
    endtask

    task automatic model_sym(input logic [1:0] s);
        int  mask = 0;
        bit  inj  = (m_mode != 0) && (m_window == 0 || m_symct < m_window);
        case (m_mode)
            1: if (m_period != 0 && inj && (m_k % m_period) < m_burst) mask = 3;
            2: if (inj && m_lfsr < m_thresh) mask = ((m_lfsr & 3) == 0) ? 3 : int'(m_lfsr & 3);
            3: begin
                if (m_left > 0) begin
                    if (inj) mask = 3;
                    m_left--;
                end else if (inj && m_lfsr < m_thresh && m_burst != 0) begin
                    mask   = 3;
                    m_left = m_burst - 1;
                end
            end
            default: ;
        endcase
        e_valid = 1;
        e_mask  = mask[1:0];
        e_sym   = s ^ mask[1:0];
        e_burst = (m_mode == 1 || m_mode == 3) && mask != 0;
        m_k++;
        m_lfsr = lfsr_step(m_lfsr);
        m_symct++;
        m_errct += popc(mask);
    endtask

    // One cycle: drive inputs, step the model, compare all outputs #1 after the edge.
    task automatic drive(input logic v, input logic [1:0] s, input logic ld);
        valid_i  = v;
        sym_i    = s;
        cfg_load = ld;
        if (ld) model_load();
        if (v) model_sym(s);
        else e_valid = 0;
        @(posedge clk);
        #1;
        cfg_load = 0;
        valid_i  = 0;
        chk("valid_o",    64'(valid_o),    64'(e_valid));
        chk("sym_o",      64'(sym_o),      64'(e_sym));
        chk("err_mask_o", 64'(err_mask_o), 64'(e_mask));
        chk("burst_o",    64'(burst_o),    64'(e_burst));
        chk("sym_ct_o",   64'(sym_ct_o),   64'(m_symct));
        chk("err_ct_o",   64'(err_ct_o),   64'(m_errct));
    endtask

    task automatic set_cfg(input int mode, input int period, input int burst,
                           input int thresh, input int seed, input int window);
        cfg_mode   = 2'(mode);
        cfg_period = 16'(period);
        cfg_burst  = 8'(burst);
        cfg_thresh = 16'(thresh);
        cfg_seed   = 16'(seed);
        cfg_window = 32'(window);
    endtask

    typedef struct {
        int         mode, period, burst, window, nsym;
        logic [1:0] sym;
        int         exp_err;
    } vec_t;

    vec_t vt[6];
    int   run_len;
    bit   found;

    initial begin
        // Expected error totals are hand-derived from the periodic rule.
        vt[0] = '{mode:0, period:0,  burst:0, window:0,   nsym:100, sym:2'b10, exp_err:0};
        vt[1] = '{mode:1, period:16, burst:1, window:256, nsym:300, sym:2'b01, exp_err:32};
        vt[2] = '{mode:1, period:8,  burst:3, window:0,   nsym:16,  sym:2'b00, exp_err:12};
        vt[3] = '{mode:1, period:0,  burst:5, window:0,   nsym:20,  sym:2'b11, exp_err:0};
        vt[4] = '{mode:1, period:4,  burst:9, window:0,   nsym:10,  sym:2'b10, exp_err:20};
        vt[5] = '{mode:1, period:5,  burst:2, window:7,   nsym:12,  sym:2'b01, exp_err:8};

        rst = 1; cfg_load = 0; valid_i = 0; sym_i = 0;
        set_cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o",  64'(valid_o),    64'd0);
        chk("reset sym_o",    64'(sym_o),      64'd0);
        chk("reset mask",     64'(err_mask_o), 64'd0);
        chk("reset sym_ct",   64'(sym_ct_o),   64'd0);
        chk("reset err_ct",   64'(err_ct_o),   64'd0);
        chk("reset burst_o",  64'(burst_o),    64'd0);
        rst = 0;
        drive(1, 2'b11, 0);   // mode 0 straight out of reset: passes clean

        // Table-driven periodic / clean scenarios.
        for (int r = 0; r < 6; r++) begin
            set_cfg(vt[r].mode, vt[r].period, vt[r].burst, 0, 1, vt[r].window);
            drive(1, vt[r].sym, 1);
            for (int i = 1; i < vt[r].nsym; i++) drive(1, vt[r].sym, 0);
            chk($sformatf("vec%0d sym_ct", r), 64'(sym_ct_o), 64'(vt[r].nsym));
            chk($sformatf("vec%0d err_ct", r), 64'(err_ct_o), 64'(vt[r].exp_err));
        end

        // cfg_* changes without cfg_load are ignored.
        set_cfg(0, 0, 0, 0, 1, 0);
        drive(1, 2'b10, 1);
        set_cfg(1, 2, 1, 16'hFFFF, 5, 0);
        for (int i = 0; i < 10; i++) drive(1, 2'b10, 0);
        chk("noload err_ct", 64'(err_ct_o), 64'd0);
        chk("noload sym_o",  64'(sym_o),    64'd2);

        // Load without a symbol clears counters; idle cycles hold sym_o.
        set_cfg(1, 3, 1, 0, 1, 0);
        drive(0, 2'b00, 1);
        chk("load idle sym_ct", 64'(sym_ct_o), 64'd0);
        for (int i = 0; i < 8; i++) drive(i % 2 == 0, 2'(i), 0);

        // Random mode, every symbol hit from seed 1.
        set_cfg(2, 0, 0, 16'hFFFF, 1, 0);
        drive(1, 2'(($urandom)), 1);
        for (int i = 0; i < 200; i++) drive(($urandom_range(0, 9) < 7), 2'($urandom), 0);
        chk("random err_ct", 64'(err_ct_o), 64'(m_errct));

        // Random mode with random threshold and seed (seed 0 exercised too).
        for (int r = 0; r < 3; r++) begin
            set_cfg(2, 0, 0, int'($urandom_range(0, 16'hFFFF)), (r == 0) ? 0 : int'($urandom_range(0, 16'hFFFF)), 0);
            drive(1, 2'($urandom), 1);
            for (int i = 0; i < 150; i++) drive(($urandom_range(0, 3) != 0), 2'($urandom), 0);
        end

        // Random-burst mode with gaps; observed corrupted runs are multiples of 4.
        set_cfg(3, 0, 4, 16'h2000, 16'h1234, 0);
        drive(1, 2'b01, 1);
        run_len = (err_mask_o != 0) ? 1 : 0;
        for (int i = 0; i < 800; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            drive(v, 2'($urandom), 0);
            if (v) begin
                if (err_mask_o != 0) run_len++;
                else begin
                    if (run_len != 0) chk("rburst run%4", 64'(run_len % 4), 64'd0);
                    run_len = 0;
                end
            end
        end

        // Re-load in the middle of a burst restarts counting at symbol 0.
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            drive(1, 2'b00, 0);
            if (m_left > 0) found = 1;
        end
        chk("rburst mid-burst found", 64'(found), 64'd1);
        set_cfg(3, 0, 4, 16'h0000, 16'h1234, 0);
        drive(1, 2'b10, 1);
        chk("reload sym_ct", 64'(sym_ct_o), 64'd1);
        chk("reload err_ct", 64'(err_ct_o), 64'd0);
        chk("reload sym_o",  64'(sym_o),    64'd2);
        for (int i = 0; i < 6; i++) drive(1, 2'b10, 0);

        // Reset asserted during a periodic burst clears outputs at once.
        set_cfg(1, 8, 3, 0, 1, 0);
        drive(1, 2'b01, 1);
        drive(1, 2'b01, 0);
        chk("pre-rst burst_o", 64'(burst_o), 64'd1);
        rst = 1;
        #1;
        chk("rst valid_o", 64'(valid_o),    64'd0);
        chk("rst sym_o",   64'(sym_o),      64'd0);
        chk("rst mask",    64'(err_mask_o), 64'd0);
        chk("rst burst_o", 64'(burst_o),    64'd0);
        chk("rst sym_ct",  64'(sym_ct_o),   64'd0);
        chk("rst err_ct",  64'(err_ct_o),   64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        set_cfg(1, 8, 3, 0, 1, 0);
        drive(1, 2'b01, 1);
        chk("post-rst sym_ct", 64'(sym_ct_o), 64'd1);
        chk("post-rst mask",   64'(err_mask_o), 64'd3);
        for (int i = 0; i < 10; i++) drive(1, 2'b01, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
